// File: rtl/alu_wide_seq.sv
// alu_wide_seq: runs 64-bit arithmetic/logic operations as two passes
// (low word, then high word) through an external combinational 32-bit ALU,
// chaining the carry through the ALU's PrevC input.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready           request handshake; req_op, req_a, req_b
//   resp_valid/resp_ready         response handshake; resp_result, resp_flags {N,Z,C,V}
//   alu_a, alu_b, alu_control,
//   alu_shiftop, alu_prevc        drive to the ALU (shiftop tied 000)
//   alu_result, alu_flags         ALU outputs, captured at LO/HI edges
//   busy                          high whenever the sequencer is not idle
//
// Optional build macro ALU_WIDE_SEQ_FLUSH_EN adds a `flush` input that aborts
// an in-flight operation and blocks acceptance while asserted in IDLE.
//
// State   | meaning
// IDLE    | ready for a request, ALU inputs parked at zero
// LO      | low-word pass on the ALU, carry and low-Z captured at the edge
// HI      | high-word pass with carry in, response registered at the edge
// DONE    | response held until resp_ready
module alu_wide_seq (
  input  logic        clk,
  input  logic        reset_n,
`ifdef ALU_WIDE_SEQ_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  output logic [2:0]  alu_shiftop,
  output logic        alu_prevc,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ORR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_RSB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        carry_q, carry_d;
  logic        zlo_q, zlo_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_result_q, resp_result_d;
  logic [3:0]  resp_flags_q, resp_flags_d;

  logic        flush_i;
  logic [3:0]  ctrl_lo;
  logic [3:0]  ctrl_hi;
  logic        prevc_lo;

`ifdef ALU_WIDE_SEQ_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Subtract-type ops use the with-carry encodings on both passes; seeding
  // PrevC with 1 on the low pass makes a + ~b + 1 a true subtract, so C=1
  // means no borrow. ADD needs ADC only on the high pass.
  always_comb begin
    ctrl_lo  = 4'b0100;
    ctrl_hi  = 4'b0101;
    prevc_lo = 1'b0;
    case (op_q)
      OP_SUB, OP_CMP: begin
        ctrl_lo  = 4'b0110;
        ctrl_hi  = 4'b0110;
        prevc_lo = 1'b1;
      end
      OP_RSB: begin
        ctrl_lo  = 4'b0111;
        ctrl_hi  = 4'b0111;
        prevc_lo = 1'b1;
      end
      OP_AND: begin
        ctrl_lo = 4'b0000;
        ctrl_hi = 4'b0000;
      end
      OP_ORR: begin
        ctrl_lo = 4'b1100;
        ctrl_hi = 4'b1100;
      end
      OP_XOR: begin
        ctrl_lo = 4'b0001;
        ctrl_hi = 4'b0001;
      end
      default: begin
        ctrl_lo = 4'b0100;
        ctrl_hi = 4'b0101;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_lo_d      = res_lo_q;
    carry_d       = carry_q;
    zlo_d         = zlo_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    req_ready     = 1'b0;
    alu_a         = 32'd0;
    alu_b         = 32'd0;
    alu_control   = 4'b0000;
    alu_prevc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = ~flush_i;
        if (req_valid && !flush_i) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = S_LO;
        end
      end
      S_LO: begin
        alu_a       = a_q[31:0];
        alu_b       = b_q[31:0];
        alu_control = ctrl_lo;
        alu_prevc   = prevc_lo;
        res_lo_d    = alu_result;
        carry_d     = alu_flags[1];
        zlo_d       = alu_flags[2];
        state_d     = S_HI;
      end
      S_HI: begin
        alu_a         = a_q[63:32];
        alu_b         = b_q[63:32];
        alu_control   = ctrl_hi;
        alu_prevc     = carry_q;
        resp_result_d = (op_q == OP_CMP) ? 64'd0 : {alu_result, res_lo_q};
        // Z must cover all 64 bits, so the low pass's Z gates the high one.
        resp_flags_d  = {alu_flags[3], zlo_q & alu_flags[2], alu_flags[1], alu_flags[0]};
        resp_valid_d  = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort discards the in-flight result; the previous response stays put.
    if (flush_i && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      resp_valid_d  = 1'b0;
      resp_result_d = resp_result_q;
      resp_flags_d  = resp_flags_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      op_q          <= 3'd0;
      a_q           <= 64'd0;
      b_q           <= 64'd0;
      res_lo_q      <= 32'd0;
      carry_q       <= 1'b0;
      zlo_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= 64'd0;
      resp_flags_q  <= 4'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_lo_q      <= res_lo_d;
      carry_q       <= carry_d;
      zlo_q         <= zlo_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign alu_shiftop = 3'b000;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: provides a 32-bit ALU model on the ALU port, then
// compares responses against a 64-bit arithmetic reference model.
module tb_alu_wide_seq;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_result;
  logic [3:0]  resp_flags;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [2:0]  alu_shiftop;
  logic        alu_prevc;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        busy;

  int total;
  int bad;

  alu_wide_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef ALU_WIDE_SEQ_FLUSH_EN
    .flush       (flush),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_shiftop (alu_shiftop),
    .alu_prevc   (alu_prevc),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit ALU: ARM-style data-processing ops, flags {N,Z,C,V}.
  logic [32:0] alu_sum;
  logic        alu_c;
  logic        alu_v;
  always_comb begin
    alu_sum = 33'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_control)
      4'b0100: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = alu_sum[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      4'b0101: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_prevc};
        alu_c = alu_sum[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      4'b0110: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {32'd0, alu_prevc};
        alu_c = alu_sum[32];
        alu_v = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      4'b0111: begin
        alu_sum = {1'b0, alu_b} + {1'b0, ~alu_a} + {32'd0, alu_prevc};
        alu_c = alu_sum[32];
        alu_v = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_b[31]);
      end
      4'b0000: alu_sum = {1'b0, alu_a & alu_b};
      4'b0001: alu_sum = {1'b0, alu_a ^ alu_b};
      4'b1100: alu_sum = {1'b0, alu_a | alu_b};
      default: alu_sum = 33'd0;
    endcase
    alu_result = alu_sum[31:0];
    alu_flags  = {alu_sum[31], (alu_sum[31:0] == 32'd0), alu_c, alu_v};
  end

  // 64-bit reference: plain arithmetic on the whole operands.
  function automatic void ref_model(input logic [2:0] op, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] r,
                                    output logic [3:0] f);
    logic c, v;
    logic [64:0] s;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000, 3'b110: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'b010, 3'b111: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'b011: begin
        r = b - a;
        c = (b >= a);
        v = (a[63] != b[63]) && (r[63] != b[63]);
      end
      3'b100:  r = a & b;
      3'b001:  r = a | b;
      default: r = a ^ b;
    endcase
    f = {r[63], (r == 64'd0), c, v};
    if (op == 3'b111) r = 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // hold>0 keeps resp_ready low in DONE while a competing request is presented.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold);
    logic [63:0] er;
    logic [3:0]  ef;
    ref_model(op, a, b, er, ef);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    req_a     = ~a;
    check("busy_lo", busy, 1'b1);
    check("resp_valid_lo", resp_valid, 1'b0);
    check("alu_a_lo", alu_a, a[31:0]);
    check("alu_shiftop", alu_shiftop, 3'b000);
    @(posedge clk); @(negedge clk);
    check("resp_valid_hi", resp_valid, 1'b0);
    check("alu_b_hi", alu_b, b[63:32]);
    @(posedge clk); @(negedge clk);
    check("resp_valid_done", resp_valid, 1'b1);
    check("result", resp_result, er);
    check("flags", resp_flags, ef);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check("hold_req_ready", req_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
      check("hold_valid", resp_valid, 1'b1);
      check("hold_result", resp_result, er);
      check("hold_flags", resp_flags, ef);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_released", resp_valid, 1'b0);
    check("busy_released", busy, 1'b0);
    check("req_ready_released", req_ready, 1'b1);
    req_valid = 1'b0;
  endtask

  logic [63:0] edge_vals [6];

  initial begin
    logic [2:0]  rop;
    logic [63:0] ra, rb;
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_a      = 64'd0;
    req_b      = 64'd0;
    resp_ready = 1'b0;
    edge_vals[0] = 64'd0;
    edge_vals[1] = 64'hFFFFFFFF_FFFFFFFF;
    edge_vals[2] = 64'h7FFFFFFF_FFFFFFFF;
    edge_vals[3] = 64'h80000000_00000000;
    edge_vals[4] = 64'h00000000_FFFFFFFF;
    edge_vals[5] = 64'hFFFFFFFF_00000000;

    #2;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_result", resp_result, 64'd0);
    check("rst_resp_flags", resp_flags, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_alu_control", alu_control, 4'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_prevc", alu_prevc, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    run_op(3'b000, 64'h00000000_FFFFFFFF, 64'd1, 0);
    check("add_carry_chain", resp_result, 64'h00000001_00000000);
    run_op(3'b000, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 0);
    check("add_ovf_flags", resp_flags, 4'b1001);
    run_op(3'b010, 64'd0, 64'd1, 0);
    check("sub_borrow_flags", resp_flags, 4'b1000);
    run_op(3'b010, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 0);
    check("sub_equal_flags", resp_flags, 4'b0110);
    run_op(3'b111, 64'd3, 64'd7, 0);
    check("cmp_result", resp_result, 64'd0);
    check("cmp_nzc", resp_flags[3:1], 3'b100);
    run_op(3'b100, 64'hFFFFFFFF_00000000, 64'h00000000_FFFFFFFF, 0);
    check("and_zero_z", resp_flags[2], 1'b1);
    run_op(3'b011, 64'd5, 64'd2, 0);
    run_op(3'b110, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 0);
    run_op(3'b001, 64'h0F0F0000_00000000, 64'h00000000_0000F0F0, 0);
    run_op(3'b101, 64'hAAAAAAAA_55555555, 64'hAAAAAAAA_55555554, 0);

    // Backpressure with a competing request held during DONE.
    run_op(3'b000, 64'h00000001_80000000, 64'h00000002_80000000, 5);
    run_op(3'b010, 64'h00000001_00000000, 64'd1, 0);

    // Reset asserted during the high pass.
    req_valid = 1'b1;
    req_op    = 3'b000;
    req_a     = 64'h1234;
    req_b     = 64'h5678;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midreset_resp_valid", resp_valid, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_result", resp_result, 64'd0);
    check("midreset_flags", resp_flags, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("post_reset_no_resp", resp_valid, 1'b0);
    @(negedge clk);
    run_op(3'b000, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 0);

`ifdef ALU_WIDE_SEQ_FLUSH_EN
    req_valid = 1'b1;
    req_op    = 3'b000;
    req_a     = 64'd9;
    req_b     = 64'd9;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_no_resp", resp_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("flush_still_no_resp", resp_valid, 1'b0);
    end
    req_valid = 1'b1;
    flush     = 1'b1;
    #1;
    check("flush_idle_req_ready", req_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    check("flush_idle_not_accepted", busy, 1'b0);
    flush     = 1'b0;
    req_valid = 1'b0;
    run_op(3'b010, 64'd100, 64'd1, 0);
`endif

    // Randomised operations, with operands sometimes drawn from edge values.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = edge_vals[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) rb = edge_vals[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
